// File: rtl/align_assign_rr_arb.sv
// align_assign_rr_arb
//
// Round-robin arbiter that shares one WIDTH-bit output datapath between NREQ
// requesters. A grant is held for a whole burst (up to req_last), but no longer
// than MAX_HOLD beats. Every grant is followed by one IDLE cycle in which the
// next requester is picked, scanning upward from the one after the last grant.
//
// Handshake: a beat moves on any cycle where valid and ready are both high at
// posedge clk. Valid never depends on ready. Ready may depend on valid.
// Data and last are meaningful only while valid is high.
//
// Ports:
//   clk        clock, all state on posedge
//   rst        synchronous reset, active-high
//   req_valid  per-requester beat valid                  [NREQ]
//   req_ready  per-requester beat accept                 [NREQ]
//   req_data   requester k data at [k*WIDTH +: WIDTH]    [NREQ*WIDTH]
//   req_last   per-requester last beat of burst          [NREQ]
//   out_valid  beat valid toward the shared datapath
//   out_ready  shared datapath accepts the beat
//   out_data   beat data                                 [WIDTH]
//   out_src    index of the granted requester            [SRCW]
//   out_last   final beat of this grant (burst end or hold cap reached)
//   busy       high while a grant is active (XFER state)

module align_assign_rr_arb #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8,
    localparam int SRCW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SRCW-1:0]       out_src,
    output logic                  out_last,
    output logic                  busy
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    state_e          fsm_q, fsm_d;
    logic [SRCW-1:0] grant_q, grant_d;
    logic [SRCW-1:0] last_grant_q, last_grant_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;

    logic [WIDTH-1:0] data_arr [NREQ];
    logic             any_valid;
    logic [SRCW-1:0]  pick;
    logic [SRCW:0]    scan_idx;
    logic             beat;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            data_arr[k] = req_data[k*WIDTH +: WIDTH];
        end
    end

    // Round-robin pick: first valid requester at offsets 1..NREQ from the
    // last grant, wrapping past NREQ-1. The extra bit in scan_idx keeps the
    // unwrapped sum from overflowing before the wrap correction.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        scan_idx  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            scan_idx = {1'b0, last_grant_q} + (SRCW+1)'(i);
            if (scan_idx >= (SRCW+1)'(NREQ)) begin
                scan_idx = scan_idx - (SRCW+1)'(NREQ);
            end
            if (!any_valid && req_valid[scan_idx[SRCW-1:0]]) begin
                any_valid = 1'b1;
                pick      = scan_idx[SRCW-1:0];
            end
        end
    end

    // Outputs are a pass-through of the granted requester only, so nothing
    // from ungranted inputs can reach them. In IDLE every output is zero.
    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_src   = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        if (fsm_q == XFER) begin
            busy               = 1'b1;
            out_src            = grant_q;
            out_valid          = req_valid[grant_q];
            out_data           = data_arr[grant_q];
            out_last           = req_valid[grant_q] &&
                                 (req_last[grant_q] || beat_cnt_q == 8'(MAX_HOLD-1));
            req_ready[grant_q] = out_ready;
        end
        beat = out_valid && out_ready;
    end

    always_comb begin
        fsm_d        = fsm_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (fsm_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    fsm_d      = XFER;
                end
            end
            XFER: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // A capped release looks the same as a burst end here;
                    // the requester simply continues on its next grant.
                    if (out_last) begin
                        last_grant_d = grant_q;
                        fsm_d        = IDLE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q        <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SRCW'(NREQ-1);
            beat_cnt_q   <= '0;
        end else begin
            fsm_q        <= fsm_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_align_assign_rr_arb.sv
`timescale 1ns/1ps

module tb_align_assign_rr_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_data;
  logic [3:0]  req_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_src;
  logic        out_last;
  logic        busy;

  int n_vec;
  int n_err;
  logic [3:0] exp_q[$];

  align_assign_rr_arb #(
    .NREQ(4),
    .WIDTH(4),
    .MAX_HOLD(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data(req_data),
    .req_last(req_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_src(out_src),
    .out_last(out_last),
    .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [3:0] d, input logic l);
    req_valid[k]       = v;
    req_data[k*4 +: 4] = d;
    req_last[k]        = l;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard pop for streamed beats
  task automatic sb_check(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      chk(tag, 32'(out_data), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    int src_seq [5];
    src_seq = '{0, 1, 2, 3, 0};
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // 1. reset then idle
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t1_out_valid", 32'(out_valid), 32'd0);
      chk("t1_req_ready", 32'(req_ready), 32'd0);
      chk("t1_busy",      32'(busy),      32'd0);
      chk("t1_out_src",   32'(out_src),   32'd0);
      tick();
    end

    // 2. single burst from req 2
    out_ready = 1'b1;
    set_req(2, 1'b1, 4'hA, 1'b0);
    #1;
    chk("t2_idle_valid", 32'(out_valid), 32'd0);
    chk("t2_idle_busy",  32'(busy),      32'd0);
    tick();
    #1;
    chk("t2_a_valid", 32'(out_valid), 32'd1);
    chk("t2_a_src",   32'(out_src),   32'd2);
    chk("t2_a_data",  32'(out_data),  32'hA);
    chk("t2_a_last",  32'(out_last),  32'd0);
    chk("t2_a_ready", 32'(req_ready), 32'b0100);
    chk("t2_a_busy",  32'(busy),      32'd1);
    tick();
    set_req(2, 1'b1, 4'hB, 1'b0);
    #1;
    chk("t2_b_data", 32'(out_data), 32'hB);
    chk("t2_b_last", 32'(out_last), 32'd0);
    tick();
    set_req(2, 1'b1, 4'hC, 1'b1);
    #1;
    chk("t2_c_data", 32'(out_data), 32'hC);
    chk("t2_c_last", 32'(out_last), 32'd1);
    tick();
    set_req(2, 1'b0, 4'h0, 1'b0);
    #1;
    chk("t2_end_busy",  32'(busy),      32'd0);
    chk("t2_end_valid", 32'(out_valid), 32'd0);
    chk("t2_end_data",  32'(out_data),  32'd0);
    tick();

    // 3. round-robin rotation from a fresh reset (scan starts at 0)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, 4'(k + 5), 1'b1);
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("t3_bubble_busy", 32'(busy), 32'd0);
      tick();
      #1;
      chk("t3_src",   32'(out_src),   32'(src_seq[g]));
      chk("t3_data",  32'(out_data),  32'(src_seq[g] + 5));
      chk("t3_last",  32'(out_last),  32'd1);
      chk("t3_valid", 32'(out_valid), 32'd1);
      tick();
    end
    for (int k = 0; k < 4; k++) set_req(k, 1'b0, 4'h0, 1'b0);
    tick();

    // 4. hold cap: req 1 streams 12 beats, req 3 waits with a 1-beat burst
    for (int b = 1; b <= 12; b++) exp_q.push_back(4'(b));
    set_req(1, 1'b1, 4'h1, 1'b0);
    set_req(3, 1'b1, 4'hF, 1'b1);
    #1;
    chk("t4_idle_busy", 32'(busy), 32'd0);
    tick();
    for (int b = 1; b <= 8; b++) begin
      set_req(1, 1'b1, 4'(b), 1'b0);
      #1;
      chk("t4_src1", 32'(out_src), 32'd1);
      chk("t4_last", 32'(out_last), (b == 8) ? 32'd1 : 32'd0);
      sb_check("t4_data");
      tick();
    end
    set_req(1, 1'b1, 4'h9, 1'b0);
    #1;
    chk("t4_bubble_busy",  32'(busy),      32'd0);
    chk("t4_bubble_valid", 32'(out_valid), 32'd0);
    tick();
    #1;
    chk("t4_src3",   32'(out_src),   32'd3);
    chk("t4_data3",  32'(out_data),  32'hF);
    chk("t4_last3",  32'(out_last),  32'd1);
    chk("t4_ready3", 32'(req_ready), 32'b1000);
    tick();
    set_req(3, 1'b0, 4'h0, 1'b0);
    #1;
    chk("t4_bubble2_busy", 32'(busy), 32'd0);
    tick();
    for (int b = 9; b <= 12; b++) begin
      set_req(1, 1'b1, 4'(b), (b == 12));
      #1;
      chk("t4_resume_src", 32'(out_src), 32'd1);
      chk("t4_resume_last", 32'(out_last), (b == 12) ? 32'd1 : 32'd0);
      sb_check("t4_resume_data");
      tick();
    end
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    set_req(1, 1'b0, 4'h0, 1'b0);
    #1;
    chk("t4_end_busy", 32'(busy), 32'd0);
    tick();

    // 5. backpressure on req 0; cap must land on beat 8 despite the stall
    set_req(0, 1'b1, 4'h1, 1'b0);
    #1;
    chk("t5_idle_busy", 32'(busy), 32'd0);
    tick();
    for (int b = 1; b <= 8; b++) begin
      set_req(0, 1'b1, 4'(b), 1'b0);
      if (b == 3) begin
        for (int s = 0; s < 3; s++) begin
          out_ready = 1'b0;
          #1;
          chk("t5_stall_ready", 32'(req_ready), 32'd0);
          chk("t5_stall_data",  32'(out_data),  32'd3);
          chk("t5_stall_valid", 32'(out_valid), 32'd1);
          chk("t5_stall_src",   32'(out_src),   32'd0);
          chk("t5_stall_busy",  32'(busy),      32'd1);
          chk("t5_stall_last",  32'(out_last),  32'd0);
          tick();
        end
        out_ready = 1'b1;
      end
      #1;
      chk("t5_data",  32'(out_data),  32'(b));
      chk("t5_ready", 32'(req_ready), 32'b0001);
      chk("t5_last",  32'(out_last),  (b == 8) ? 32'd1 : 32'd0);
      tick();
    end
    set_req(0, 1'b0, 4'h0, 1'b0);
    #1;
    chk("t5_end_busy", 32'(busy), 32'd0);
    tick();

    // 6. reset in the middle of a burst from req 3
    set_req(3, 1'b1, 4'h1, 1'b0);
    #1;
    chk("t6_idle_busy", 32'(busy), 32'd0);
    tick();
    #1;
    chk("t6_b1_src",  32'(out_src),  32'd3);
    chk("t6_b1_data", 32'(out_data), 32'd1);
    tick();
    set_req(3, 1'b1, 4'h2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1, 1'b1, 4'h5, 1'b0);
    set_req(3, 1'b1, 4'h3, 1'b0);
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_busy",  32'(busy),      32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_last",  32'(out_last),  32'd0);
    tick();
    #1;
    chk("t6_regrant_src",  32'(out_src),  32'd1);
    chk("t6_regrant_data", 32'(out_data), 32'd5);
    set_req(1, 1'b0, 4'h0, 1'b0);
    set_req(3, 1'b0, 4'h0, 1'b0);
    tick();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
